// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand handshake in, result plus flags out.
// The master drives operands and accepts results; the slave is the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             op_err;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow, op_err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow, op_err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready request and response, an iterative shift-add
// multiplier, variable shifts and signed compare.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SRL = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h3;
    localparam logic [3:0] OP_SRA = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_SLT = 4'h9;

    typedef enum logic [1:0] {IDLE, MUL_RUN, RESP} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               negative_q;
    logic               carry_q;
    logic               overflow_q;
    logic               opErr_q;
    logic               busy_q;
    logic               outValid_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;

    logic               accept;
    logic               isMul;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               addOvf;
    logic               subOvf;
    logic [WIDTH-1:0]   result_d;
    logic               carry_d;
    logic               overflow_d;
    logic               opErr_d;
    logic [2*WIDTH-1:0] acc_d;

    // In RESP a new request can only be taken when the pending result leaves this cycle.
    assign bus.in_ready = rst_n && ((state_q == IDLE) || ((state_q == RESP) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign isMul        = MUL_EN && (bus.op == OP_MUL);
    assign shamt        = bus.b[SHW-1:0];
    assign sum          = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff         = {1'b0, bus.a} - {1'b0, bus.b};
    assign addOvf       = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign subOvf       = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    assign acc_d        = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        opErr_d    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                carry_d    = sum[WIDTH];
                overflow_d = addOvf;
            end
            OP_SUB: begin
                result_d   = diff[WIDTH-1:0];
                carry_d    = ~diff[WIDTH];
                overflow_d = subOvf;
            end
            OP_SRL: result_d = bus.a >> shamt;
            OP_SLL: result_d = bus.a << shamt;
            OP_SRA: result_d = $signed(bus.a) >>> shamt;
            OP_AND: result_d = bus.a & bus.b;
            OP_OR:  result_d = bus.a | bus.b;
            OP_XOR: result_d = bus.a ^ bus.b;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            // MUL only lands here when the multiplier is disabled, so it is illegal too.
            default: begin
                carry_d    = sum[WIDTH];
                overflow_d = addOvf;
                opErr_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            opErr_q    <= 1'b0;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if ((state_q == RESP) && bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                    if (accept) begin
                        if (isMul) begin
                            mcand_q    <= {{WIDTH{1'b0}}, bus.a};
                            mplier_q   <= bus.b;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b1;
                            outValid_q <= 1'b0;
                            state_q    <= MUL_RUN;
                        end else begin
                            result_q   <= result_d;
                            zero_q     <= (result_d == '0);
                            negative_q <= result_d[WIDTH-1];
                            carry_q    <= carry_d;
                            overflow_q <= overflow_d;
                            opErr_q    <= opErr_d;
                            outValid_q <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        result_q   <= acc_d[WIDTH-1:0];
                        zero_q     <= (acc_d[WIDTH-1:0] == '0);
                        negative_q <= acc_d[WIDTH-1];
                        carry_q    <= |acc_d[2*WIDTH-1:WIDTH];
                        overflow_q <= 1'b0;
                        opErr_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.op_err    = opErr_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against an arithmetic
// reference model, and hand-written multi-cycle sequences (MUL, backpressure, reset).
module tb_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference written from the arithmetic meaning of each op, using 64-bit integers.
    function automatic void refModel(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic c, output logic v, output logic e);
        longint          sx;
        longint          sy;
        longint          s;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned p;
        int              sh;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        sh = int'(y % W);
        c  = 1'b0;
        v  = 1'b0;
        e  = 1'b0;
        case (o)
            4'd1: begin
                r = x - y;
                c = (x >= y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = x >> sh;
            4'd3: r = x << sh;
            4'd4: r = W'($signed(x) >>> sh);
            4'd5: r = x & y;
            4'd6: r = x | y;
            4'd7: r = x ^ y;
            4'd8: begin
                p = ux * uy;
                r = p[W-1:0];
                c = ((p >> W) != 0);
            end
            4'd9: r = (sx < sy) ? 1 : 0;
            default: begin
                p = ux + uy;
                r = p[W-1:0];
                c = (p >= 64'h1_0000_0000);
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e = (o != 4'd0);
            end
        endcase
    endfunction

    // Drives one request, lets it be accepted, scrambles the inputs, and waits for the result.
    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output int lat);
        int g;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g == 100) checkVal("accept_timeout", 64'(g), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] r, input logic c, input logic v,
                               input logic z, input logic n, input logic e);
        checkVal({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        checkVal({tag, "_result"},    64'(bus.result),    64'(r));
        checkVal({tag, "_carry"},     64'(bus.carry),     64'(c));
        checkVal({tag, "_overflow"},  64'(bus.overflow),  64'(v));
        checkVal({tag, "_zero"},      64'(bus.zero),      64'(z));
        checkVal({tag, "_negative"},  64'(bus.negative),  64'(n));
        checkVal({tag, "_op_err"},    64'(bus.op_err),    64'(e));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int             lat;
        int             bad;
        logic [3:0]     ro;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [W-1:0]   er;
        logic           ec;
        logic           ev;
        logic           ee;

        //          op     a             b             res           c     v     z     n     e     lat
        vecs.push_back('{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'h4, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'h3, 32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h8, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 33});
        vecs.push_back('{4'hF, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'h2, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'h7, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h8, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'h6, 32'h0000000A, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'h5, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});

        bus.in_valid  = 1'b0;
        bus.op        = 4'h0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (2) @(negedge clk);
        checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkVal("reset_busy",      64'(bus.busy),      64'd0);
        checkVal("reset_result",    64'(bus.result),    64'd0);
        checkVal("reset_zero",      64'(bus.zero),      64'd0);
        checkVal("reset_carry",     64'(bus.carry),     64'd0);
        checkVal("reset_op_err",    64'(bus.op_err),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkVal($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v,
                        vecs[i].z, vecs[i].n, vecs[i].e);
        end

        for (int k = 0; k < 150; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            refModel(ro, ra, rb, er, ec, ev, ee);
            applyStimulus(ro, ra, rb, lat);
            checkVal($sformatf("rnd%0d_latency", k), 64'(lat), (ro == 4'h8) ? 64'd33 : 64'd1);
            checkOutput($sformatf("rnd%0d", k), er, ec, ev, (er == '0), er[W-1], ee);
        end

        // MUL: busy and in_ready during every iteration cycle, then the result on the 33rd.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 4'h8;
        bus.a        = 32'h00010000;
        bus.b        = 32'h00010000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'hFFFFFFFF;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!bus.busy || bus.in_ready || bus.out_valid) bad++;
        end
        checkVal("mul_busy_window_bad_cycles", 64'(bad), 64'd0);
        @(negedge clk);
        checkVal("mul_busy_after", 64'(bus.busy), 64'd0);
        checkOutput("mul_seq", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure holds the response, then four back-to-back ADDs drain one per cycle.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 4'h0;
        bus.a         = 32'd10;
        bus.b         = 32'd20;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== 32'd30 || bus.in_ready) bad++;
        end
        checkVal("backpressure_bad_cycles", 64'(bad), 64'd0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'h0;
        bus.b         = 32'd100;
        for (int k = 0; k < 4; k++) begin
            bus.a = W'(k);
            @(negedge clk);
            checkVal($sformatf("b2b%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
            checkVal($sformatf("b2b%0d_result", k), 64'(bus.result), 64'(k + 100));
        end
        bus.in_valid = 1'b0;

        // Reset in the middle of a MUL drops it and clears everything at once.
        applyStimulus(4'h0, 32'd1, 32'd1, lat);
        checkOutput("pre_reset_add", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 4'h8;
        bus.a        = 32'd3;
        bus.b        = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("midmul_reset_busy",      64'(bus.busy),      64'd0);
        checkVal("midmul_reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkVal("midmul_reset_result",    64'(bus.result),    64'd0);
        checkVal("midmul_reset_zero",      64'(bus.zero),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) bad++;
        end
        checkVal("midmul_no_result_cycles", 64'(bad), 64'd0);
        checkVal("midmul_in_ready", 64'(bus.in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
